// File: rtl/cp0_if.sv
// Coprocessor-0 bus between the M stage and the CP0 block.
// The pipeline side drives requests; CP0 returns read data and the trap request.
interface cp0_if;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;
  logic        int_req;

  modport master (
    output en, cp0_addr, cp0_in, vpc,
    output bd_in, exc_code_in, hw_int, exl_clr,
    input  cp0_out, epc_out, int_req
  );

  modport slave (
    input  en, cp0_addr, cp0_in, vpc,
    input  bd_in, exc_code_in, hw_int, exl_clr,
    output cp0_out, epc_out, int_req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt arbitration.
// Trap request is combinational; state updates on the following edge.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2025
) (
  input logic    clk,
  input logic    reset,
  cp0_if.slave   bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic int_irq;
  logic exc_req;
  logic trap;
  logic wr_sr;
  logic wr_epc;

  assign int_irq = (|(bus.hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
  assign trap    = int_irq | exc_req;
  assign wr_sr   = bus.en & (bus.cp0_addr == 5'd12);
  assign wr_epc  = bus.en & (bus.cp0_addr == 5'd14);

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = bus.hw_int;
    if (trap) begin
      // Software writes in a trap cycle are dropped.
      exl_d = 1'b1;
      bd_d  = bus.bd_in;
      exc_d = int_irq ? 5'd0 : bus.exc_code_in;
      epc_d = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
    end else begin
      if (wr_sr) begin
        im_d  = bus.cp0_in[15:10];
        exl_d = bus.cp0_in[1];
        ie_d  = bus.cp0_in[0];
      end
      if (wr_epc) epc_d = bus.cp0_in;
      if (bus.exl_clr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    bus.cp0_out = '0;
    unique case (bus.cp0_addr)
      5'd12:   bus.cp0_out = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   bus.cp0_out = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      5'd14:   bus.cp0_out = epc_q;
      5'd15:   bus.cp0_out = PRID_VALUE;
      default: bus.cp0_out = '0;
    endcase
  end

  assign bus.epc_out = epc_q;
  assign bus.int_req = trap;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed and randomized checks of cp0_unit against a word-level model.
// Model keeps SR/Cause/EPC as architectural 32-bit words.
module tb_cp0_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cp0_if bus ();

  cp0_unit #(.PRID_VALUE(32'h0000_2025)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_irq();
    return (|(bus.hw_int & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_irq() | ((bus.exc_code_in != 5'd0) & ~m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2025;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.en = 0; bus.cp0_addr = 0; bus.cp0_in = 0;
    bus.vpc = 0; bus.bd_in = 0; bus.exc_code_in = 0;
    bus.hw_int = 0; bus.exl_clr = 0; reset = 0;
  endtask

  // Check outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    logic req, irq;
    logic [31:0] ip;
    #1;
    req = m_req();
    irq = m_irq();
    chk("int_req", {31'd0, bus.int_req}, {31'd0, req});
    chk("cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
    chk("epc_out", bus.epc_out, m_epc);
    @(posedge clk);
    ip = {16'd0, bus.hw_int, 10'd0};
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (req) begin
      m_sr = m_sr | 32'd2;
      m_cause = {bus.bd_in, 31'd0} | ip |
                {25'd0, (irq ? 5'd0 : bus.exc_code_in), 2'd0};
      m_epc = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ip;
      if (bus.en && bus.cp0_addr == 5'd12)
        m_sr = bus.cp0_in & 32'h0000_FC03;
      if (bus.en && bus.cp0_addr == 5'd14) m_epc = bus.cp0_in;
      if (bus.exl_clr) m_sr = m_sr & ~32'd2;
    end
    #1;
  endtask

  initial begin
    logic [31:0] rst_rd [4];
    rst_rd[0] = 32'd0; rst_rd[1] = 32'd0;
    rst_rd[2] = 32'd0; rst_rd[3] = 32'h0000_2025;
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      bus.cp0_addr = 5'(12 + i);
      #1;
      chk("rst_read", bus.cp0_out, rst_rd[i]);
    end
    chk("rst_epc", bus.epc_out, 32'd0);
    chk("rst_req", {31'd0, bus.int_req}, 32'd0);

    idle();
    bus.en = 1; bus.cp0_addr = 12; bus.cp0_in = 32'h0000_FC01;
    tick();
    idle();
    bus.hw_int = 6'b000100; bus.vpc = 32'h0000_2000;
    #1;
    chk("hw_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    bus.cp0_addr = 12;
    #1;
    chk("hw_sr", bus.cp0_out, 32'h0000_FC03);
    chk("hw_epc", bus.epc_out, 32'h0000_2000);
    chk("hw_req_off", {31'd0, bus.int_req}, 32'd0);
    bus.cp0_addr = 13;
    #1;
    chk("hw_cause", bus.cp0_out, 32'h0000_1000);
    tick();

    idle();
    bus.exl_clr = 1;
    tick();
    idle();
    bus.en = 1; bus.cp0_addr = 12; bus.cp0_in = 32'h0000_FC00;
    tick();
    idle();
    bus.exc_code_in = 5'd10; bus.vpc = 32'h0000_3010; bus.bd_in = 1;
    #1;
    chk("ri_req", {31'd0, bus.int_req}, 32'd1);
    tick();
    idle();
    bus.cp0_addr = 13;
    #1;
    chk("ri_cause", bus.cp0_out, 32'h8000_0028);
    chk("ri_epc", bus.epc_out, 32'h0000_300C);

    bus.exl_clr = 1;
    tick();
    idle();
    bus.exc_code_in = 5'd10; bus.vpc = 32'h0000_4000;
    bus.en = 1; bus.cp0_addr = 14; bus.cp0_in = 32'h0000_1234;
    tick();
    idle();
    #1;
    chk("drop_epc", bus.epc_out, 32'h0000_4000);

    bus.en = 1; bus.cp0_addr = 12; bus.cp0_in = 32'h0000_FC03;
    bus.hw_int = 6'b000001;
    tick();
    bus.en = 0;
    #1;
    chk("exl_mask", {31'd0, bus.int_req}, 32'd0);
    bus.exl_clr = 1;
    #1;
    chk("clr_same", {31'd0, bus.int_req}, 32'd0);
    tick();
    bus.exl_clr = 0;
    #1;
    chk("clr_next", {31'd0, bus.int_req}, 32'd1);
    bus.exc_code_in = 5'd4;
    tick();
    bus.exc_code_in = 0;
    bus.cp0_addr = 13;
    #1;
    chk("prio_code", {27'd0, bus.cp0_out[6:2]}, 32'd0);
    bus.en = 1; bus.cp0_in = 32'hFFFF_FFFF;
    tick();
    bus.en = 0;
    #1;
    chk("cause_ro", bus.cp0_out, 32'h0000_0400);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      bus.en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: bus.cp0_addr = 12;
        1: bus.cp0_addr = 13;
        2: bus.cp0_addr = 14;
        3: bus.cp0_addr = 15;
        default: bus.cp0_addr = 5'($urandom);
      endcase
      bus.cp0_in = $urandom;
      bus.vpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.bd_in = 1'($urandom);
      bus.exc_code_in = ($urandom_range(0, 4) == 0) ?
                        5'($urandom) : 5'd0;
      bus.hw_int = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      bus.exl_clr = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block of the P7 pipelined MIPS core: holds SR, Cause, EPC and PRId, arbitrates exceptions and hardware interrupts, and drives the pipeline-wide trap request consumed by every pipeline register, including the flush-to-handler load of the fetch/decode register. It sits at the M stage (macro-PC point): it receives the exception code, branch-delay flag and PC of the instruction currently in M. It records EPC/Cause and serves `mfc0`/`mtc0`/`eret`.

## Interface
- PRID_VALUE, 32'h0000_2025, constant returned on reads of register 15.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- en  in  1  `mtc0` write strobe (M stage).
- cp0_addr  in  5  register number for read and write.
- cp0_in  in  32  write data.
- vpc  in  32  PC of the instruction in M (macro PC).
- bd_in  in  1  instruction in M sits in a branch-delay slot.
- exc_code_in  in  5  exception code of the M instruction; 0 = none.
- hw_int  in  6  external interrupt lines, level-sensitive.
- exl_clr  in  1  `eret` in M.
- cp0_out  out  32  read data, combinational from `cp0_addr`.
- epc_out  out  32  current EPC register.
- int_req  out  1  trap request: flush all pipeline registers, PC <= handler.

## Operation
- SR (12): IM = bits[15:10], EXL = bit[1], IE = bit[0]; all other bits read 0.
- Cause (13): BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]; others read 0.
- EPC (14): 32-bit, stored as given.
- PRId (15): reads PRID_VALUE.
- Any other address reads 0.
- int_irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_req = (exc_code_in != 0) & ~SR.EXL.
- int_req = int_irq | exc_req.
- Interrupt has priority over exception: on int_irq, the latched ExcCode = 0 (Int); otherwise exc_code_in.
- Per-edge priority: reset > int_req > exl_clr / en.
  - reset: every register is cleared to 0.
  - int_req: EXL <= 1; Cause.BD <= bd_in; Cause.ExcCode as above; EPC <= bd_in ? vpc - 4 : vpc, modulo 2^32. Any en or exl_clr in the same cycle is dropped.
  - Otherwise with en:
    - addr 12 writes IM, EXL and IE from the matching bits of cp0_in.
    - addr 14 writes all of EPC.
    - Writes to 13, 15 or other addresses are ignored.
  - Otherwise with exl_clr: EXL <= 0. If en to SR occurs in the same cycle, EXL <= 0 still wins, and the IM/IE write is applied.
- Cause.IP <= hw_int on every non-reset edge, including trap edges. This field is read-only to software.
- cp0_out and epc_out show pre-edge register values. There is no internal forwarding, so a write is visible on the next cycle.

## Timing
- Reset values: cp0_out = 0 for addr 12/13/14 and PRID_VALUE for addr 15; epc_out = 0; int_req = 0 (EXL = 0, IE = 0).
- int_req is combinational and valid in the same cycle as its cause. The pipeline flushes at that edge.
- Masking of further requests: EXL reads 1 from the cycle after the trap edge, so int_req falls then. Held hw_int or repeated exc_code_in do not re-trap until EXL is cleared.
- exl_clr at edge N: EXL = 0 from cycle N+1. A pending, unmasked interrupt raises int_req in cycle N+1.
- hw_int is sampled into IP one cycle late. int_req itself uses live hw_int.
- Reset in the middle of a trap cycle: reset wins, and no register keeps trap state.

## Test plan
- Reset, then read addr 12/13/14/15.
  - Reads 0, 0, 0, 32'h0000_2025.
  - epc_out = 0, int_req = 0.
- mtc0 SR = 32'h0000_FC01, then hw_int = 6'b000100.
  - int_req = 1 in the same cycle.
  - After the edge: Cause.ExcCode = 0, EPC = vpc, SR = 32'h0000_FC03.
  - int_req = 0 the next cycle.
- exc_code_in = 5'd10 (RI), vpc = 32'h0000_3010, bd_in = 1, IE = 0.
  - int_req = 1.
  - Cause = 32'h8000_0028, EPC = 32'h0000_300C.
- Trap with en = 1, addr 14, cp0_in = 32'h1234 in the same cycle.
  - EPC holds the trap value, not 32'h1234.
- With EXL = 1 and hw_int held active, pulse exl_clr.
  - int_req stays 0 until the cycle after the exl_clr edge, then goes to 1.
- exc_code_in = 5'd4 together with an unmasked interrupt.
  - Latched ExcCode = 0.
  - Write to Cause via mtc0 leaves Cause unchanged.
